// File: rtl/operand_streamer.sv
// Operand lane streamer: strided tile fetch from memory, one row per beat to the buffer.
// Build option OPERAND_STREAMER_ZERO_PAD_EN: inactive lanes are driven valid with zero data.
//
// state | meaning
// IDLE  | waiting for start; parameters latched on start
// ISSUE | issuing row reads while credits remain
// DRAIN | all reads granted, waiting for the last beat to leave
// DONE  | one-cycle done pulse, then back to IDLE
module operand_streamer #(
  parameter int COLS       = 4,
  parameter int DW         = 8,
  parameter int AW         = 16,
  parameter int RW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [AW-1:0]              base_addr,
  input  logic [RW-1:0]              num_rows,
  input  logic [$clog2(COLS+1)-1:0]  num_cols,
  input  logic [RW-1:0]              stride,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_req,
  output logic [AW-1:0]              mem_addr,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [COLS*DW-1:0]         mem_rdata,
  output logic [COLS-1:0]            o_valid,
  output logic [COLS*DW-1:0]         o_data,
  input  logic                       o_ready
);

  localparam int CW = $clog2(COLS+1);
  localparam int KW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   PTR_ONE  = 1;
  localparam logic [KW-1:0] CRED_MAX = KW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       rows_q, stride_q, issued_q, emitted_q;
  logic [CW-1:0]       cols_q;
  logic [AW-1:0]       addr_q;
  logic [KW-1:0]       credits_q;
  logic [PW:0]         wr_ptr_q, rd_ptr_q;
  logic [COLS*DW-1:0]  fifo_mem [FIFO_DEPTH];
  logic                out_vld_q;
  logic [COLS*DW-1:0]  out_data_q;

  logic grant, last_grant, accept, xfer, slot_free;
  logic fifo_empty, fifo_full, push, pop;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    mem_req    = (state_q == S_ISSUE) && (credits_q != '0) && (issued_q < rows_q);
    grant      = mem_req && mem_gnt;
    last_grant = grant && (issued_q == rows_q - RW'(1));
    // Responses outside an active transfer belong to an abandoned one.
    accept     = mem_rvalid && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    xfer       = out_vld_q && o_ready;
    slot_free  = !out_vld_q || o_ready;
    pop        = slot_free && !fifo_empty;
    push       = accept && !(slot_free && fifo_empty);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_rows == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_grant) state_d = S_DRAIN;
      S_DRAIN: if (emitted_q == rows_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rows_q    <= '0;
      stride_q  <= '0;
      cols_q    <= '0;
      addr_q    <= '0;
      issued_q  <= '0;
      emitted_q <= '0;
      credits_q <= CRED_MAX;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && start) begin
        rows_q    <= num_rows;
        stride_q  <= stride;
        cols_q    <= num_cols;
        addr_q    <= base_addr;
        issued_q  <= '0;
        emitted_q <= '0;
        credits_q <= CRED_MAX;
      end else begin
        if (grant) begin
          issued_q <= issued_q + RW'(1);
          addr_q   <= addr_q + AW'(stride_q);
        end
        if (xfer) emitted_q <= emitted_q + RW'(1);
        // A credit covers a row from grant until it leaves the output register.
        if (grant && !xfer)      credits_q <= credits_q - KW'(1);
        else if (xfer && !grant) credits_q <= credits_q + KW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (slot_free) begin
        out_vld_q <= pop || accept;
        if (pop)         out_data_q <= fifo_mem[rd_ptr_q[PW-1:0]];
        else if (accept) out_data_q <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= mem_rdata;
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign mem_addr = addr_q;

  always_comb begin
    o_valid = '0;
    o_data  = out_data_q;
    for (int c = 0; c < COLS; c++) begin
`ifdef OPERAND_STREAMER_ZERO_PAD_EN
      o_valid[c] = out_vld_q;
      if (CW'(c) >= cols_q) o_data[c*DW +: DW] = '0;
`else
      o_valid[c] = out_vld_q && (CW'(c) < cols_q);
`endif
    end
  end

`ifndef SYNTHESIS
  // Credits bound outstanding reads, so a response into a full FIFO is a memory-side bug.
  rvalid_into_full_fifo: assert property (@(posedge clk) disable iff (rst)
    !(mem_rvalid && fifo_full));
`endif

endmodule

// File: tb/tb_operand_streamer.sv
// Directed table-driven bench for operand_streamer with an in-order latency memory model.
// Lane expectations follow OPERAND_STREAMER_ZERO_PAD_EN when the bench is built with it.
module tb_operand_streamer;

  logic        clk = 1'b0;
  logic        rst, start, mem_gnt, mem_rvalid, o_ready;
  logic [15:0] base_addr, mem_addr;
  logic [7:0]  num_rows, stride;
  logic [2:0]  num_cols;
  logic        busy, done, mem_req;
  logic [31:0] mem_rdata, o_data;
  logic [3:0]  o_valid;

  operand_streamer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .num_cols(num_cols), .stride(stride), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] base;
    logic [7:0]  rows;
    logic [2:0]  cols;
    logic [7:0]  stride;
    int          lat;
    bit          gnt_tog;
    bit          rdy_tog;
    int          restart_at;
    logic [15:0] last_addr;
    logic [3:0]  valid;
    int          done_wait;
    bit          no_bubble;
  } vec_t;

  typedef struct { logic [3:0] v; logic [31:0] d; int cyc; } beat_t;
  typedef struct { logic [15:0] a; int due; } rq_t;

  int n_chk = 0, n_fail = 0;
  int edge_n = 0, lat = 2, max_out = 0, done_cnt = 0, req_cnt = 0;
  bit gnt_tog = 0, rdy_tog = 0;
  rq_t         rq[$];
  logic [15:0] granted[$];
  beat_t       beats[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mdata(input logic [15:0] a);
    return {a[7:0] + 8'h81, a[7:0] ^ 8'h5A, a[15:8], a[7:0]};
  endfunction

  function automatic logic [31:0] exp_row(input logic [15:0] a, input logic [2:0] cols);
    logic [31:0] r;
    r = mdata(a);
`ifdef OPERAND_STREAMER_ZERO_PAD_EN
    for (int c = 0; c < 4; c++) if (c >= cols) r[c*8 +: 8] = 8'h00;
`endif
    return r;
  endfunction

  // Memory and sink model: drives inputs for the coming edge just after each edge.
  bit          prev_wait = 0;
  logic [15:0] prev_addr = '0;
  always begin
    int k;
    @(posedge clk); #1;
    edge_n++;
    k = edge_n + 1;
    if (prev_wait) chk("addr held until gnt", {mem_req, mem_addr}, {1'b1, prev_addr});
    mem_gnt = gnt_tog ? ~edge_n[0] : 1'b1;
    o_ready = rdy_tog ? edge_n[0] : 1'b1;
    prev_wait = mem_req && !mem_gnt;
    prev_addr = mem_addr;
    if (mem_req) req_cnt++;
    if (mem_req && mem_gnt) begin
      rq.push_back('{a: mem_addr, due: k + lat});
      granted.push_back(mem_addr);
    end
    if (rq.size() > max_out) max_out = rq.size();
    if (rq.size() > 0 && rq[0].due == k) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mdata(rq[0].a);
      void'(rq.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
  end

  // Beat monitor: records transfers and checks that held beats do not move.
  bit          held = 0;
  logic [3:0]  held_v;
  logic [31:0] held_d;
  always @(negedge clk) begin
    if (rst) held = 0;
    else begin
      if (held) chk("held beat stable", {o_valid, o_data}, {held_v, held_d});
      if (o_valid != 4'h0 && o_ready) beats.push_back('{v: o_valid, d: o_data, cyc: edge_n});
      held   = (o_valid != 4'h0) && !o_ready;
      held_v = o_valid;
      held_d = o_data;
      if (done) done_cnt++;
    end
  end

  task automatic run(input vec_t v);
    bit got;
    int waited;
    logic [15:0] ea;
    logic [3:0]  ev;
    @(posedge clk); #2;
    done_cnt = 0; req_cnt = 0; max_out = 0;
    granted.delete(); beats.delete();
    lat = v.lat; gnt_tog = v.gnt_tog; rdy_tog = v.rdy_tog;
    start = 1'b1; base_addr = v.base; num_rows = v.rows; num_cols = v.cols; stride = v.stride;
    @(posedge clk); #2;
    start = 1'b0;
    got = 0; waited = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      waited = n + 1;
      if (done) got = 1;
      else if (n == v.restart_at) begin
        start = 1'b1; num_rows = 8'd0; base_addr = 16'hDEAD;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk("done seen", got, 1);
    if (v.done_wait > 0) chk("done latency", waited, v.done_wait);
    @(negedge clk);
    chk("idle after done", {busy, done}, 2'b00);
    repeat (2) @(negedge clk);
    chk("done pulses", done_cnt, 1);
    chk("grant count", granted.size(), v.rows);
    for (int i = 0; i < granted.size(); i++) begin
      ea = v.base + 16'(i * v.stride);
      chk($sformatf("addr[%0d]", i), granted[i], ea);
    end
    if (v.rows > 0 && granted.size() > 0) chk("last addr", granted[granted.size()-1], v.last_addr);
    chk("beat count", beats.size(), v.rows);
`ifdef OPERAND_STREAMER_ZERO_PAD_EN
    ev = 4'hF;
`else
    ev = v.valid;
`endif
    for (int i = 0; i < beats.size() && i < v.rows; i++) begin
      ea = v.base + 16'(i * v.stride);
      chk($sformatf("beat[%0d] valid", i), beats[i].v, ev);
      chk($sformatf("beat[%0d] data", i), beats[i].d, exp_row(ea, v.cols));
    end
    chk("outstanding within depth", max_out <= 4, 1);
    if (v.rows == 0) chk("no mem_req on empty", req_cnt, 0);
    if (v.no_bubble && beats.size() == v.rows)
      chk("bubble-free span", beats[v.rows-1].cyc - beats[0].cyc, v.rows - 1);
  endtask

  vec_t vecs[6];
  vec_t post_vec;

  initial begin
    bit got;
    vecs[0] = '{16'h0010, 8'd4,  3'd4, 8'd1,  2, 0, 0, -1, 16'h0013, 4'b1111, 0, 0};
    vecs[1] = '{16'h0100, 8'd8,  3'd4, 8'd1,  3, 0, 1,  5, 16'h0107, 4'b1111, 0, 0};
    vecs[2] = '{16'hFFFE, 8'd3,  3'd3, 8'd5,  2, 0, 0, -1, 16'h0008, 4'b0111, 0, 0};
    vecs[3] = '{16'h1234, 8'd0,  3'd4, 8'd1,  2, 0, 0, -1, 16'h0000, 4'b1111, 1, 0};
    vecs[4] = '{16'h0200, 8'd16, 3'd4, 8'd1,  1, 0, 0, -1, 16'h020F, 4'b1111, 0, 1};
    vecs[5] = '{16'h0300, 8'd5,  3'd1, 8'h10, 4, 1, 1, -1, 16'h0340, 4'b0001, 0, 0};
    post_vec = '{16'h0600, 8'd4, 3'd4, 8'd2,  2, 0, 0, -1, 16'h0606, 4'b1111, 0, 0};

    rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; num_cols = '0; stride = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; o_ready = 1'b1;
    repeat (2) @(posedge clk); #3;
    chk("reset outputs", {busy, done, mem_req, mem_addr, o_valid, o_data}, '0);
    rst = 1'b0;

    foreach (vecs[i]) run(vecs[i]);

    // Reset in the middle of a 6-row transfer, with reads still in flight.
    @(posedge clk); #2;
    lat = 3; gnt_tog = 0; rdy_tog = 0; beats.delete();
    start = 1'b1; base_addr = 16'h0500; num_rows = 8'd6; num_cols = 3'd4; stride = 8'd1;
    @(posedge clk); #2;
    start = 1'b0;
    got = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(posedge clk); #2;
      if (beats.size() >= 2) got = 1;
    end
    chk("two beats before reset", got, 1);
    #1 rst = 1'b1;
    #1 chk("outputs cleared by reset", {busy, done, mem_req, mem_addr, o_valid, o_data}, '0);
    repeat (2) @(posedge clk); #3;
    rst = 1'b0;
    beats.delete();
    repeat (8) @(negedge clk);
    chk("late rvalid ignored", beats.size(), 0);
    chk("idle after reset", {busy, o_valid}, '0);
    run(post_vec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
